dd_axil_regs: RTL

AXI4-Lite responder that fronts the display driver at base 0x20000000. It decodes CPU writes into control pulses and a word FIFO of packed LED pixels, and returns driver status on reads. It sits between the AXI interconnect, which strips the base so only the low address bits arrive, and the display driver's strip loader and sequencer.

---
 rtl/dd_axil_regs_if.sv | 39 +++
 rtl/dd_axil_regs.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dd_axil_regs_if.sv
// AXI4-Lite bus bundle for the display-driver register block.
interface dd_axil_regs_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/dd_axil_regs.sv
// AXI4-Lite register front-end for the display driver: CTRL pulses, LED word FIFO, STATUS.
// Define DD_STATUS_READ_EN to build the STATUS read mux; otherwise every read returns 0/OKAY.
//
// state    | meaning
// W_ACCEPT | collecting AW and W (either order); side effect fires when both are held
// W_RESP   | bvalid high, waiting for bready
// R_IDLE   | arready high, waiting for AR
// R_DATA   | rvalid high, rdata held until rready
module dd_axil_regs #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clock,
  input  logic            resetn,
  dd_axil_regs_if.slave   s_axi,
  output logic [31:0]     led_word_o,
  output logic            led_valid_o,
  input  logic            led_ready_i,
  output logic            write_done_o,
  output logic            next_o,
  output logic            sync_o,
  output logic            overflow_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WA = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_ACCEPT, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  write_done_q, write_done_d;
  logic                  next_q, next_d;
  logic                  sync_q, sync_d;
  logic                  ovf_q, ovf_d;
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic [31:0]           mem_q [FIFO_DEPTH];
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, aw_done, w_done, wr_fire;
  logic [ADDR_WIDTH-1:0] awaddr_eff;
  logic [31:0]           wdata_eff;
  logic [3:0]            wstrb_eff;
  logic                  is_ctrl, is_led, wr_ok, push_req, push, drop, pop;
  logic                  ovf_clr, empty, full, ar_hs;
  logic [31:0]           rd_data;
  logic [1:0]            rd_resp;
  logic                  unused_bits;

  assign unused_bits = ^{s_axi.awprot, s_axi.awaddr[1:0], s_axi.araddr};

  // A channel may have been latched in an earlier cycle or be handshaking right now.
  assign aw_hs      = s_axi.awvalid & awready_q;
  assign w_hs       = s_axi.wvalid & wready_q;
  assign aw_done    = aw_got_q | aw_hs;
  assign w_done     = w_got_q | w_hs;
  assign awaddr_eff = aw_got_q ? awaddr_q : s_axi.awaddr;
  assign wdata_eff  = w_got_q ? wdata_q : s_axi.wdata;
  assign wstrb_eff  = w_got_q ? wstrb_q : s_axi.wstrb;
  assign wr_fire    = (wstate_q == W_ACCEPT) & aw_done & w_done;

  assign is_ctrl  = awaddr_eff[ADDR_WIDTH-1:2] == WA'(0);
  assign is_led   = awaddr_eff[ADDR_WIDTH-1:2] == WA'(1);
  assign wr_ok    = is_ctrl | (is_led & (wstrb_eff == 4'hF));
  assign push_req = wr_fire & is_led & (wstrb_eff == 4'hF);

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  // Fullness uses the registered pointers, so a same-cycle pop never admits a push.
  assign push    = push_req & ~full;
  assign drop    = push_req & full;
  assign pop     = ~empty & led_ready_i;
  assign ovf_clr = wr_fire & is_ctrl & wdata_eff[31];

  always_comb begin
    wstate_d     = wstate_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    aw_got_d     = aw_got_q;
    w_got_d      = w_got_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    write_done_d = 1'b0;
    next_d       = 1'b0;
    sync_d       = 1'b0;
    case (wstate_q)
      W_ACCEPT: begin
        aw_got_d  = aw_done;
        w_got_d   = w_done;
        awaddr_d  = awaddr_eff;
        wdata_d   = wdata_eff;
        wstrb_d   = wstrb_eff;
        awready_d = ~aw_done;
        wready_d  = ~w_done;
        if (wr_fire) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = (wr_ok && !drop) ? RESP_OKAY : RESP_SLVERR;
          wstate_d  = W_RESP;
          if (is_ctrl) begin
            write_done_d = wdata_eff[0];
            next_d       = wdata_eff[8];
            sync_d       = wdata_eff[12];
          end
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (s_axi.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_ACCEPT;
        end
      end
      default: wstate_d = W_ACCEPT;
    endcase
  end

  // Set wins over a same-cycle clear.
  assign ovf_d    = (ovf_q & ~ovf_clr) | drop;
  assign wr_ptr_d = wr_ptr_q + (PW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (PW+1)'(pop);

`ifdef DD_STATUS_READ_EN
  logic [PW:0] level;
  logic [31:0] status;
  assign level  = wr_ptr_q - rd_ptr_q;
  assign status = {21'd0, ovf_q, full, empty, 8'(level)};

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axi.araddr[ADDR_WIDTH-1:2])
      WA'(0), WA'(1): rd_data = '0;
      WA'(2):         rd_data = status;
      default:        rd_resp = RESP_SLVERR;
    endcase
  end
`else
  assign rd_data = '0;
  assign rd_resp = RESP_OKAY;
`endif

  assign ar_hs = s_axi.arvalid & arready_q;

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_data;
          rresp_d   = rd_resp;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (s_axi.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wstate_q     <= W_ACCEPT;
      rstate_q     <= R_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_got_q     <= 1'b0;
      w_got_q      <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      write_done_q <= 1'b0;
      next_q       <= 1'b0;
      sync_q       <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      aw_got_q     <= aw_got_d;
      w_got_q      <= w_got_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      write_done_q <= write_done_d;
      next_q       <= next_d;
      sync_q       <= sync_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_eff;
  end

  assign led_valid_o  = ~empty;
  assign led_word_o   = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign write_done_o = write_done_q;
  assign next_o       = next_q;
  assign sync_o       = sync_q;
  assign overflow_o   = ovf_q;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
endmodule
